// File: rtl/ibex_pkg.sv
// Shared types and constants for the CHERI PCC / branch-redirect logic.
//   pcc_redirect_state_e : redirect FSM states
//   CHERI_ADDR_W         : width of the capability address field
//   CheriCapWidthDefault : default compressed-capability width
//   CheriExcWidth        : width of the CHERI check-failure cause vector
//   CheriRootHi          : upper (non-address) bits of the root capability, tag set
package ibex_pkg;

  localparam int CHERI_ADDR_W         = 32;
  localparam int CheriCapWidthDefault = 91;
  localparam int CheriExcWidth        = 5;

  // Bit 58 (the tag, capability bit 90) is set: the reset PCC is a valid root cap.
  localparam logic [CheriCapWidthDefault-CHERI_ADDR_W-1:0] CheriRootHi =
    59'h4AB_CDEF_0123_4567;

  typedef enum logic [1:0] {
    PccIdle     = 2'd0,
    PccRedirect = 2'd1,
    PccExc      = 2'd2
  } pcc_redirect_state_e;

endpackage

// File: rtl/ibex_cheri_pcc_redirect.sv
// Owns the architectural PCC. Consumes the EX-stage branch outcome, issues
// fetch redirects to IF (req/ack), raises CHERI branch exceptions to the
// controller (req/ack) and stalls EX while either is pending. A controller
// trap (trap_set_i) overrides everything and redirects fetch to trap_pcc_i.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   ex_valid_i, branch_req_i,
//   branch_decision_i        branch accepted when all three high and idle
//   branch_is_cap_i          target is a full capability, else integer addr
//   branch_target_i          branch target
//   branch_exc_i/_cause_i    CHERI check failure on target and its cause
//   trap_set_i, trap_pcc_i   trap entry / xRET: install PCC and redirect
//   redirect_req_o/_addr_o   fetch redirect to IF, acked by redirect_ack_i
//   exc_req_o, exc_cause_o   exception to controller, acked by exc_ack_i
//   pcc_o                    architectural PCC
//   stall_ex_o               high whenever not idle
//   taken_cnt_o              saturating count of taken branch redirects
module ibex_cheri_pcc_redirect
  import ibex_pkg::*;
#(
  parameter int                          CheriCapWidth = CheriCapWidthDefault,
  parameter logic [31:0]                 BootAddr      = 32'h0000_0080,
  parameter logic [CheriCapWidth-33:0]   PccRootHi     = CheriRootHi
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_valid_i,
  input  logic                      branch_req_i,
  input  logic                      branch_decision_i,
  input  logic                      branch_is_cap_i,
  input  logic [CheriCapWidth-1:0]  branch_target_i,
  input  logic                      branch_exc_i,
  input  logic [CheriExcWidth-1:0]  branch_exc_cause_i,
  input  logic                      trap_set_i,
  input  logic [CheriCapWidth-1:0]  trap_pcc_i,
  output logic                      redirect_req_o,
  output logic [31:0]               redirect_addr_o,
  input  logic                      redirect_ack_i,
  output logic                      exc_req_o,
  output logic [CheriExcWidth-1:0]  exc_cause_o,
  input  logic                      exc_ack_i,
  output logic [CheriCapWidth-1:0]  pcc_o,
  output logic                      stall_ex_o,
  output logic [31:0]               taken_cnt_o
);

  pcc_redirect_state_e state_q, state_d;

  logic [CheriCapWidth-1:0] pcc_q, pcc_d;
  logic [31:0]              addr_q, addr_d;
  logic [CheriExcWidth-1:0] cause_q, cause_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     accept;

  assign accept = ex_valid_i & branch_req_i & branch_decision_i & (state_q == PccIdle);

  // NOTE: every variable gets its hold value before any branch, so paths
  // that do not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    pcc_d   = pcc_q;
    addr_d  = addr_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;

    if (trap_set_i) begin
      // Trap wins over acks and a simultaneous accept; not counted as taken.
      pcc_d      = trap_pcc_i;
      pcc_d[0]   = 1'b0;
      addr_d     = {trap_pcc_i[31:1], 1'b0};
      state_d    = PccRedirect;
    end else begin
      unique case (state_q)
        PccIdle: begin
          if (accept) begin
            if (branch_exc_i) begin
              cause_d = branch_exc_cause_i;
              state_d = PccExc;
            end else begin
              if (branch_is_cap_i) begin
                pcc_d = branch_target_i;
              end else begin
                pcc_d = {pcc_q[CheriCapWidth-1:32], branch_target_i[31:0]};
              end
              pcc_d[0] = 1'b0;
              addr_d   = {branch_target_i[31:1], 1'b0};
              cnt_d    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
              state_d  = PccRedirect;
            end
          end
        end
        PccRedirect: if (redirect_ack_i) state_d = PccIdle;
        PccExc:      if (exc_ack_i)      state_d = PccIdle;
        default:     state_d = PccIdle;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= PccIdle;
      pcc_q          <= {PccRootHi, BootAddr};
      addr_q         <= '0;
      cause_q        <= '0;
      cnt_q          <= '0;
      redirect_req_o <= 1'b0;
      exc_req_o      <= 1'b0;
      stall_ex_o     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcc_q          <= pcc_d;
      addr_q         <= addr_d;
      cause_q        <= cause_d;
      cnt_q          <= cnt_d;
      // Flags are registered from the next state so no output decodes logic.
      redirect_req_o <= (state_d == PccRedirect);
      exc_req_o      <= (state_d == PccExc);
      stall_ex_o     <= (state_d != PccIdle);
    end
  end

  assign pcc_o           = pcc_q;
  assign redirect_addr_o = addr_q;
  assign exc_cause_o     = cause_q;
  assign taken_cnt_o     = cnt_q;

endmodule

// File: tb/tb_ibex_cheri_pcc_redirect.sv
// Directed bench for ibex_cheri_pcc_redirect. Inputs change 1 time unit
// after a rising edge; outputs are compared at that same point, i.e. they
// reflect the register state loaded at the preceding edge.
module tb_ibex_cheri_pcc_redirect;
  import ibex_pkg::*;

  localparam int CW = 91;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ex_valid = 0, branch_req = 0, branch_decision = 0, branch_is_cap = 0;
  logic [CW-1:0]   branch_target = '0;
  logic            branch_exc = 0;
  logic [4:0]      branch_exc_cause = '0;
  logic            trap_set = 0;
  logic [CW-1:0]   trap_pcc = '0;
  logic            redirect_req, redirect_ack = 0;
  logic [31:0]     redirect_addr;
  logic            exc_req, exc_ack = 0;
  logic [4:0]      exc_cause;
  logic [CW-1:0]   pcc;
  logic            stall_ex;
  logic [31:0]     taken_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [CW-1:0] RESET_PCC = {59'h4AB_CDEF_0123_4567, 32'h0000_0080};
  localparam logic [58:0]   CAP_HI    = 59'h5A5_A5A5_A5A5_A5A5;
  localparam logic [58:0]   TRAP_HI   = 59'h7FF_FFFF_FFFF_FFFF;

  ibex_cheri_pcc_redirect dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ex_valid_i         (ex_valid),
    .branch_req_i       (branch_req),
    .branch_decision_i  (branch_decision),
    .branch_is_cap_i    (branch_is_cap),
    .branch_target_i    (branch_target),
    .branch_exc_i       (branch_exc),
    .branch_exc_cause_i (branch_exc_cause),
    .trap_set_i         (trap_set),
    .trap_pcc_i         (trap_pcc),
    .redirect_req_o     (redirect_req),
    .redirect_addr_o    (redirect_addr),
    .redirect_ack_i     (redirect_ack),
    .exc_req_o          (exc_req),
    .exc_cause_o        (exc_cause),
    .exc_ack_i          (exc_ack),
    .pcc_o              (pcc),
    .stall_ex_o         (stall_ex),
    .taken_cnt_o        (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] observed,
                       input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic is_cap, input logic [CW-1:0] tgt, input logic exc,
                        input logic [4:0] cause);
    ex_valid = 1; branch_req = 1; branch_decision = 1;
    branch_is_cap = is_cap; branch_target = tgt;
    branch_exc = exc; branch_exc_cause = cause;
  endtask

  task automatic branch_clear();
    ex_valid = 0; branch_req = 0; branch_decision = 0;
    branch_is_cap = 0; branch_exc = 0;
  endtask

  initial begin
    // ---- reset, then 5 idle cycles
    step(); step();
    rst = 0;
    repeat (5) step();
    check("rst_pcc",      pcc, RESET_PCC);
    check("rst_tag",      pcc[CW-1], 1'b1);
    check("rst_req",      {redirect_req, exc_req, stall_ex}, 3'b000);
    check("rst_addr",     redirect_addr, 32'h0);
    check("rst_cause",    exc_cause, 5'h0);
    check("rst_cnt",      taken_cnt, 32'd0);

    // ---- integer jump to 0x1235, ack in the third request cycle
    branch(1'b0, {59'h0, 32'h0000_1235}, 1'b0, 5'h0);
    step();
    branch_clear();
    check("int_req1",     {redirect_req, stall_ex}, 2'b11);
    check("int_addr",     redirect_addr, 32'h0000_1234);
    check("int_pcc",      pcc, {59'h4AB_CDEF_0123_4567, 32'h0000_1234});
    check("int_cnt",      taken_cnt, 32'd1);
    step();
    check("int_req2",     {redirect_req, stall_ex}, 2'b11);
    step();
    check("int_req3",     {redirect_req, stall_ex}, 2'b11);
    check("int_addr3",    redirect_addr, 32'h0000_1234);
    redirect_ack = 1;
    step();
    redirect_ack = 0;
    check("int_done",     {redirect_req, stall_ex}, 2'b00);

    // ---- capability jump, ack in same cycle as req, back-to-back branch
    branch(1'b1, {CAP_HI, 32'h0000_2000}, 1'b0, 5'h0);
    step();
    branch_clear();
    check("cap_req",      redirect_req, 1'b1);
    check("cap_pcc",      pcc, {CAP_HI, 32'h0000_2000});
    check("cap_cnt",      taken_cnt, 32'd2);
    redirect_ack = 1;
    step();
    redirect_ack = 0;
    check("cap_idle",     {redirect_req, stall_ex}, 2'b00);
    branch(1'b0, {59'h0, 32'h0000_3000}, 1'b0, 5'h0);
    step();
    branch_clear();
    check("b2b_req",      redirect_req, 1'b1);
    check("b2b_addr",     redirect_addr, 32'h0000_3000);
    check("b2b_pcc",      pcc, {CAP_HI, 32'h0000_3000});
    check("b2b_cnt",      taken_cnt, 32'd3);
    redirect_ack = 1;
    step();
    redirect_ack = 0;

    // ---- CHERI exception on branch target
    branch(1'b0, {59'h0, 32'h0000_9000}, 1'b1, 5'b00100);
    step();
    branch_clear();
    check("exc_req",      {exc_req, redirect_req, stall_ex}, 3'b101);
    check("exc_cause",    exc_cause, 5'b00100);
    check("exc_pcc",      pcc, {CAP_HI, 32'h0000_3000});
    check("exc_cnt",      taken_cnt, 32'd3);
    step();
    check("exc_hold",     {exc_req, exc_cause}, {1'b1, 5'b00100});
    exc_ack = 1;
    step();
    exc_ack = 0;
    check("exc_done",     {exc_req, stall_ex}, 2'b00);

    // ---- trap while redirect pending; simultaneous ack is ignored
    branch(1'b0, {59'h0, 32'h0000_4000}, 1'b0, 5'h0);
    step();
    branch_clear();
    check("pre_trap_cnt", taken_cnt, 32'd4);
    trap_set = 1; trap_pcc = {TRAP_HI, 32'h0000_0101}; redirect_ack = 1;
    step();
    trap_set = 0; redirect_ack = 0;
    check("trap_req",     {redirect_req, stall_ex}, 2'b11);
    check("trap_addr",    redirect_addr, 32'h0000_0100);
    check("trap_pcc",     pcc, {TRAP_HI, 32'h0000_0100});
    check("trap_cnt",     taken_cnt, 32'd4);
    redirect_ack = 1;
    step();
    redirect_ack = 0;
    check("trap_done",    redirect_req, 1'b0);

    // ---- not-taken branch, invalid branch, stray acks: nothing happens
    branch(1'b0, {59'h0, 32'h0000_5000}, 1'b0, 5'h0);
    branch_decision = 0;
    step();
    check("nt_idle",      {redirect_req, exc_req, stall_ex}, 3'b000);
    branch_decision = 1; ex_valid = 0;
    redirect_ack = 1; exc_ack = 1;
    step();
    branch_clear(); redirect_ack = 0; exc_ack = 0;
    check("nv_idle",      {redirect_req, exc_req, stall_ex}, 3'b000);
    check("nv_pcc",       pcc, {TRAP_HI, 32'h0000_0100});
    check("nv_cnt",       taken_cnt, 32'd4);

    // ---- asynchronous reset during a pending redirect
    branch(1'b0, {59'h0, 32'h0000_6000}, 1'b0, 5'h0);
    step();
    branch_clear();
    check("pre_rst_req",  redirect_req, 1'b1);
    #2 rst = 1;
    #1;
    check("arst_req",     {redirect_req, stall_ex}, 2'b00);
    check("arst_pcc",     pcc, RESET_PCC);
    check("arst_cnt",     taken_cnt, 32'd0);
    step();
    rst = 0;
    step();
    check("post_rst",     {redirect_req, exc_req, stall_ex}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
